pipelined_adder: RTL and testbench

Parametrised, pipelined add/subtract unit that generalises the team's fixed 16-bit ripple adder to any WIDTH split across STAGES registered carry segments. It carries a valid/ready handshake on both sides, so it drops into streaming datapaths that need a registered adder with backpressure. It reports carry-out and two's-complement overflow alongside the sum.

---
 rtl/pipelined_adder.sv | 172 +++++++++++++++++
 tb/tb_pipelined_adder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder: add/subtract unit whose carry chain is cut into STAGES
// registered segments. A valid/ready handshake on both sides lets it sit in a
// streaming datapath; a full last stage with no downstream room stalls the pipe.
module pipelined_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int SEG = WIDTH / STAGES;

   logic             adv_s;
   logic             last_v_s;
   logic [WIDTH-1:0] bx_s;
   logic             cx_s;

   // Fold subtract into an add of inverted B with an inverted borrow-in
   always_comb begin
      if (sub) begin
         bx_s = ~b;
         cx_s = ~cin;
      end else begin
         bx_s = b;
         cx_s = cin;
      end
   end

   // The whole pipe moves together unless the last stage holds an unaccepted result
   assign adv_s    = ~last_v_s | out_ready;
   assign in_ready = adv_s;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      // REM: operand bits not yet added when a token enters this stage
      // LO : sum bits already finished by the stages below
      localparam int REM = WIDTH - k * SEG;
      localparam int LO  = k * SEG;

      logic              v_d;
      logic              v_q;
      logic              c_d;
      logic              c_q;
      logic [LO+SEG-1:0] s_d;
      logic [LO+SEG-1:0] s_q;
      logic [LO+SEG-1:0] s_new_s;
      logic [REM-1:0]    op_a_s;
      logic [REM-1:0]    op_b_s;
      logic              cy_in_s;
      logic              v_in_s;
      logic [SEG:0]      seg_sum_s;

      if (k == 0) begin : g_src
         assign op_a_s  = a;
         assign op_b_s  = bx_s;
         assign cy_in_s = cx_s;
         assign v_in_s  = in_valid;
         assign s_new_s = seg_sum_s[SEG-1:0];
      end else begin : g_src
         assign op_a_s  = g_stage[k-1].g_fwd.a_q;
         assign op_b_s  = g_stage[k-1].g_fwd.b_q;
         assign cy_in_s = g_stage[k-1].c_q;
         assign v_in_s  = g_stage[k-1].v_q;
         assign s_new_s = {seg_sum_s[SEG-1:0], g_stage[k-1].s_q};
      end

      // This stage's slice of A and B plus the carry handed up from below
      assign seg_sum_s = {1'b0, op_a_s[SEG-1:0]} + {1'b0, op_b_s[SEG-1:0]}
                       + {{SEG{1'b0}}, cy_in_s};

      // Load from the predecessor on advance, otherwise hold the token
      always_comb begin
         if (adv_s) begin
            v_d = v_in_s;
            c_d = seg_sum_s[SEG];
            s_d = s_new_s;
         end else begin
            v_d = v_q;
            c_d = c_q;
            s_d = s_q;
         end
      end

      // Stage valid bit, segment carry and accumulated partial sum
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= {(LO+SEG){1'b0}};
         end else begin
            v_q <= v_d;
            c_q <= c_d;
            s_q <= s_d;
         end
      end

      if (k < STAGES - 1) begin : g_fwd
         // Upper operand slices still waiting for their turn in a later stage
         logic [REM-SEG-1:0] a_d;
         logic [REM-SEG-1:0] a_q;
         logic [REM-SEG-1:0] b_d;
         logic [REM-SEG-1:0] b_q;

         // Carry the unused operand slices along with the token
         always_comb begin
            if (adv_s) begin
               a_d = op_a_s[REM-1:SEG];
               b_d = op_b_s[REM-1:SEG];
            end else begin
               a_d = a_q;
               b_d = b_q;
            end
         end

         // Delay registers for the pending operand slices
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               a_q <= {(REM-SEG){1'b0}};
               b_q <= {(REM-SEG){1'b0}};
            end else begin
               a_q <= a_d;
               b_q <= b_d;
            end
         end
      end

      if (k == STAGES - 1) begin : g_last
         logic ovf_d;
         logic ovf_q;
         logic c_msb_s;

         // Carry into the top bit recovered from the top bit's own sum
         assign c_msb_s = op_a_s[SEG-1] ^ op_b_s[SEG-1] ^ seg_sum_s[SEG-1];

         // Signed overflow: carry into MSB disagrees with carry out of MSB
         always_comb begin
            if (adv_s) begin
               ovf_d = c_msb_s ^ seg_sum_s[SEG];
            end else begin
               ovf_d = ovf_q;
            end
         end

         // Overflow flag register, aligned with the final sum
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ovf_q <= 1'b0;
            end else begin
               ovf_q <= ovf_d;
            end
         end
      end
   end

   assign last_v_s  = g_stage[STAGES-1].v_q;
   assign out_valid = g_stage[STAGES-1].v_q;
   assign sum       = g_stage[STAGES-1].s_q;
   assign cout      = g_stage[STAGES-1].c_q;
   assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed and randomized checks of pipelined_adder
// (WIDTH=16, STAGES=4) using an in-order scoreboard of expected results.
module tb_pipelined_adder;

   localparam int WIDTH  = 16;
   localparam int STAGES = 4;

   typedef struct packed {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic              cin;
   logic              sub;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  sum;
   logic              cout;
   logic              ovf;

   int   compared   = 0;
   int   mismatched = 0;
   int   cyc_n      = 0;
   int   emitted    = 0;
   int   stall_seen = 0;
   logic last_acc   = 1'b0;
   logic lat_chk    = 1'b0;
   logic chk_idle   = 1'b0;
   res_t sb[$];
   int   sb_cyc[$];
   int   emit_cyc[$];

   pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so the bench can never hang
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1);
   end

   function automatic res_t mk(input logic [15:0] s, input logic c, input logic o);
      res_t r;
      r.sum  = s;
      r.cout = c;
      r.ovf  = o;
      return r;
   endfunction

   // Reference: one wide add; overflow when like-signed inputs give an unlike-signed result
   function automatic res_t model(input logic [15:0] ia, input logic [15:0] ib,
                                  input logic ic, input logic is);
      logic [15:0] bx;
      logic        cx;
      logic [16:0] r;
      res_t        o;
      bx     = is ? ~ib : ib;
      cx     = is ? ~ic : ic;
      r      = {1'b0, ia} + {1'b0, bx} + {16'b0, cx};
      o.sum  = r[15:0];
      o.cout = r[16];
      o.ovf  = (ia[15] == bx[15]) && (r[15] != ia[15]);
      return o;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive, sample at the falling edge, score, then pass the rising edge
   task automatic cyc(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                      input logic ic, input logic is, input logic ordy, input res_t ex);
      res_t er;
      int   ac;
      in_valid  = iv;
      a         = ia;
      b         = ib;
      cin       = ic;
      sub       = is;
      out_ready = ordy;
      @(negedge clk);
      cyc_n++;
      last_acc = 1'b0;
      if (chk_idle) check("idle_out_valid", {31'b0, out_valid}, 32'd0);
      if (out_valid) begin
         if (out_ready) begin
            check("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
               er = sb.pop_front();
               ac = sb_cyc.pop_front();
               check("sum", {16'b0, sum}, {16'b0, er.sum});
               check("cout", {31'b0, cout}, {31'b0, er.cout});
               check("ovf", {31'b0, ovf}, {31'b0, er.ovf});
               if (lat_chk) check("latency", cyc_n - ac, STAGES);
               emitted++;
               emit_cyc.push_back(cyc_n);
            end
         end else begin
            stall_seen++;
            check("stall_in_ready", {31'b0, in_ready}, 32'd0);
            if (sb.size() != 0) begin
               check("stall_sum", {16'b0, sum}, {16'b0, sb[0].sum});
               check("stall_cout", {31'b0, cout}, {31'b0, sb[0].cout});
               check("stall_ovf", {31'b0, ovf}, {31'b0, sb[0].ovf});
            end
         end
      end
      if (in_valid && in_ready) begin
         sb.push_back(ex);
         sb_cyc.push_back(cyc_n);
         last_acc = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, mk(16'h0000, 1'b0, 1'b0));
   endtask

   logic [15:0] ra [10];
   logic [15:0] rb [10];
   logic        rc [10];
   logic        rs [10];

   initial begin
      int i;
      int c;
      logic ordy;

      // ---- Reset state ----
      rst = 1'b1; in_valid = 1'b0; a = 16'h0000; b = 16'h0000;
      cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      #2;
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_sum", {16'b0, sum}, 32'h0000);
      check("rst_cout", {31'b0, cout}, 32'd0);
      check("rst_ovf", {31'b0, ovf}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);

      // ---- Directed vectors, latency checked ----
      lat_chk = 1'b1;
      cyc(1'b1, 16'h6000, 16'h4000, 1'b0, 1'b0, 1'b1, mk(16'hA000, 1'b0, 1'b1));
      idle(4);
      cyc(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, mk(16'h0000, 1'b1, 1'b0));
      cyc(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, mk(16'hFFFF, 1'b1, 1'b0));
      cyc(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
      cyc(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, mk(16'h7FFF, 1'b1, 1'b1));
      idle(6);
      check("dir_drained", sb.size(), 32'd0);
      check("dir_emitted", emitted, 32'd5);

      // ---- Bubbles: two results separated by exactly two empty cycles ----
      emit_cyc.delete();
      cyc(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1, mk(16'h2345, 1'b0, 1'b0));
      idle(2);
      cyc(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, mk(16'h8000, 1'b0, 1'b1));
      idle(6);
      check("bub_count", emit_cyc.size(), 32'd2);
      if (emit_cyc.size() == 2) check("bub_gap", emit_cyc[1] - emit_cyc[0], 32'd3);

      // ---- Backpressure: 10 random tokens, 3-cycle stall mid-stream ----
      lat_chk = 1'b0;
      emitted = 0;
      stall_seen = 0;
      for (int k = 0; k < 10; k++) begin
         ra[k] = 16'($urandom);
         rb[k] = 16'($urandom);
         rc[k] = 1'($urandom_range(1, 0));
         rs[k] = 1'($urandom_range(1, 0));
      end
      i = 0;
      c = 0;
      while (i < 10 && c < 60) begin
         ordy = (c < 6 || c > 8) ? 1'b1 : 1'b0;
         cyc(1'b1, ra[i], rb[i], rc[i], rs[i], ordy, model(ra[i], rb[i], rc[i], rs[i]));
         if (last_acc) i++;
         c++;
      end
      check("bp_all_accepted", i, 32'd10);
      check("bp_stall_cycles", stall_seen, 32'd3);
      c = 0;
      while (sb.size() != 0 && c < 30) begin
         idle(1);
         c++;
      end
      check("bp_drained", sb.size(), 32'd0);
      check("bp_emitted", emitted, 32'd10);
      idle(2);
      check("bp_no_dup", emitted, 32'd10);

      // ---- Reset with tokens in flight ----
      cyc(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, mk(16'h3333, 1'b0, 1'b0));
      cyc(1'b1, 16'h4444, 16'h5555, 1'b1, 1'b0, 1'b1, mk(16'h999A, 1'b0, 1'b1));
      cyc(1'b1, 16'hF000, 16'h0F00, 1'b0, 1'b0, 1'b1, mk(16'hFF00, 1'b0, 1'b0));
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("mid_rst_sum", {16'b0, sum}, 32'h0000);
      check("mid_rst_cout", {31'b0, cout}, 32'd0);
      check("mid_rst_ovf", {31'b0, ovf}, 32'd0);
      sb.delete();
      sb_cyc.delete();
      #2;
      rst = 1'b0;
      chk_idle = 1'b1;
      idle(6);
      chk_idle = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
